// File: rtl/rggen_rtl_pkg.sv
// ---------------------------------------------------------------------------
// rggen_rtl_pkg
// Shared definitions for the register-block bus bridges.
//   - Completion status encodings returned to the register block.
//   - State type for the APB bridge sequencer.
// ---------------------------------------------------------------------------
package rggen_rtl_pkg;

  // Completion status returned alongside o_ready
  localparam logic [1:0] STATUS_OKAY         = 2'b00;
  localparam logic [1:0] STATUS_EXOKAY       = 2'b01;
  localparam logic [1:0] STATUS_SLAVE_ERROR  = 2'b10;
  localparam logic [1:0] STATUS_DECODE_ERROR = 2'b11;

  // APB bridge sequencer states
  typedef enum logic [1:0] {
    BRIDGE_IDLE,
    BRIDGE_SETUP,
    BRIDGE_ACCESS,
    BRIDGE_RESPOND
  } bridge_state_e;

endpackage

// File: rtl/rggen_bus_timeout_counter.sv
// ---------------------------------------------------------------------------
// rggen_bus_timeout_counter
// Counts the cycles a bus transfer has been waiting and flags when the
// wait budget is used up.
// Parameters:
//   WIDTH - counter width in bits
//   LIMIT - number of counted cycles allowed; 0 disables expiry
// Ports:
//   clk       - clock
//   rst_n     - asynchronous active-low reset
//   i_clear   - synchronously returns the count to zero
//   i_enable  - advances the count by one
//   o_expired - high during the last allowed cycle (count == LIMIT-1)
// ---------------------------------------------------------------------------
module rggen_bus_timeout_counter #(
  parameter int WIDTH = 1,
  parameter int LIMIT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int              LAST_INT = (LIMIT > 0) ? (LIMIT - 1) : 0;
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(LAST_INT);

  logic [WIDTH-1:0] count;

  // Clear takes priority so a new transfer always starts from zero even
  // if the enable happens to be active on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (i_clear) begin
      count <= '0;
    end else if (i_enable) begin
      count <= count + WIDTH'(1);
    end
  end

  // Expiry is flagged during the final allowed cycle, so the owner can
  // terminate on the edge that closes that cycle.
  assign o_expired = (LIMIT > 0) && (count == LAST);

endmodule

// File: rtl/rggen_apb_bridge.sv
// ---------------------------------------------------------------------------
// rggen_apb_bridge
// Turns each external-register command from a register block into one
// APB3/APB4 master transfer and reports completion status back, including
// a decode error when the peripheral never answers.
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   i_valid/i_write/i_read         - command request from the register block
//   i_address/i_strobe/i_write_data- command payload
//   o_ready/o_status/o_read_data   - one-cycle completion with result
//   o_paddr/o_pprot/o_psel/o_penable/o_pwrite/o_pwdata/o_pstrb - APB master
//   i_pready/i_prdata/i_pslverr    - APB slave response
// ---------------------------------------------------------------------------
module rggen_apb_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int         DATA_WIDTH     = 32,
  parameter int         ADDRESS_WIDTH  = 7,
  parameter int         TIMEOUT_CYCLES = 16,
  parameter logic [2:0] PPROT_VALUE    = 3'b000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_valid,
  input  logic                      i_write,
  input  logic                      i_read,
  input  logic [ADDRESS_WIDTH-1:0]  i_address,
  input  logic [DATA_WIDTH/8-1:0]   i_strobe,
  input  logic [DATA_WIDTH-1:0]     i_write_data,
  output logic                      o_ready,
  output logic [1:0]                o_status,
  output logic [DATA_WIDTH-1:0]     o_read_data,
  output logic [ADDRESS_WIDTH-1:0]  o_paddr,
  output logic [2:0]                o_pprot,
  output logic                      o_psel,
  output logic                      o_penable,
  output logic                      o_pwrite,
  output logic [DATA_WIDTH-1:0]     o_pwdata,
  output logic [DATA_WIDTH/8-1:0]   o_pstrb,
  input  logic                      i_pready,
  input  logic [DATA_WIDTH-1:0]     i_prdata,
  input  logic                      i_pslverr
);

  // $clog2(1) is 0, so a disabled timeout still gets a 1-bit counter.
  localparam int COUNT_WIDTH =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  bridge_state_e state;
  logic          start_transfer;
  logic          timeout_expired;

  assign start_transfer = (state == BRIDGE_IDLE) && i_valid && (i_write || i_read);
  assign o_pprot        = PPROT_VALUE;

  // Wait-cycle budget for the ACCESS phase; restarted for every transfer.
  rggen_bus_timeout_counter #(
    .WIDTH (COUNT_WIDTH),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (start_transfer),
    .i_enable  (state == BRIDGE_ACCESS),
    .o_expired (timeout_expired)
  );

  // Sequencer and registered APB/response outputs. The APB request fields
  // are captured once when leaving IDLE, so upstream changes cannot disturb
  // an in-flight transfer. o_status/o_read_data hold until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BRIDGE_IDLE;
      o_ready     <= 1'b0;
      o_status    <= STATUS_OKAY;
      o_read_data <= '0;
      o_psel      <= 1'b0;
      o_penable   <= 1'b0;
      o_pwrite    <= 1'b0;
      o_paddr     <= '0;
      o_pwdata    <= '0;
      o_pstrb     <= '0;
    end else begin
      case (state)
        BRIDGE_IDLE: begin
          o_ready <= 1'b0;
          if (start_transfer) begin
            state    <= BRIDGE_SETUP;
            o_psel   <= 1'b1;
            o_paddr  <= i_address;
            o_pwrite <= i_write;
            o_pwdata <= i_write_data;
            o_pstrb  <= i_write ? i_strobe : '0;
          end else if (i_valid) begin
            // Neither read nor write: answer immediately, no APB traffic.
            state       <= BRIDGE_RESPOND;
            o_ready     <= 1'b1;
            o_status    <= STATUS_DECODE_ERROR;
            o_read_data <= '0;
          end
        end
        BRIDGE_SETUP: begin
          state     <= BRIDGE_ACCESS;
          o_penable <= 1'b1;
        end
        BRIDGE_ACCESS: begin
          // A response on the last allowed cycle beats the timeout.
          if (i_pready) begin
            state       <= BRIDGE_RESPOND;
            o_psel      <= 1'b0;
            o_penable   <= 1'b0;
            o_ready     <= 1'b1;
            o_status    <= i_pslverr ? STATUS_SLAVE_ERROR : STATUS_OKAY;
            o_read_data <= o_pwrite ? '0 : i_prdata;
          end else if (timeout_expired) begin
            state       <= BRIDGE_RESPOND;
            o_psel      <= 1'b0;
            o_penable   <= 1'b0;
            o_ready     <= 1'b1;
            o_status    <= STATUS_DECODE_ERROR;
            o_read_data <= '0;
          end
        end
        BRIDGE_RESPOND: begin
          state   <= BRIDGE_IDLE;
          o_ready <= 1'b0;
        end
        default: begin
          state <= BRIDGE_IDLE;
        end
      endcase
    end
  end

endmodule
